// File: rtl/gsim_host_if.sv
// Host/GSIM signal bundle for gsim_host: b-word stream in, GSIM drive/return, x-word stream out.
// The slave modport is the gsim_host view; the master modport is the host/GSIM-side view.
interface gsim_host_if;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        gs_in_en;
    logic [15:0] gs_b;
    logic        gs_out_valid;
    logic [31:0] gs_x;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    modport slave (
        input  s_valid, s_data, gs_out_valid, gs_x, m_ready,
        output s_ready, gs_in_en, gs_b, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, gs_out_valid, gs_x, m_ready,
        input  s_ready, gs_in_en, gs_b, m_valid, m_data
    );
endinterface

// File: rtl/gsim_host.sv
// Host-side sequencer for the GSIM solver: buffers N b-words, bursts them into GSIM,
// captures the contiguous N-word x result and drains it to the host over valid/ready.
module gsim_host #(
    parameter int N           = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    gsim_host_if.slave  bus,
    output logic        busy,
    output logic        err
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST  = CW'(N - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    state_e        state_q;
    logic [CW-1:0] wcnt_q, rcnt_q, dcnt_q;
    logic [CW-1:0] wcnt_d, rcnt_d, dcnt_d;
    logic [TW-1:0] timer_q;
    logic          s_ready_q, gs_in_en_q, m_valid_q, busy_q, err_q;
    logic [15:0]   gs_b_q;
    logic [31:0]   m_data_q;
    logic [15:0]   bbuf [N];
    logic [31:0]   xbuf [N];
    logic          s_accept, x_store, m_fire;

    assign wcnt_d = wcnt_q + CW'(1);
    assign rcnt_d = rcnt_q + CW'(1);
    assign dcnt_d = dcnt_q + CW'(1);

    assign s_accept = (state_q == ST_LOAD) && bus.s_valid && s_ready_q;
    assign x_store  = ((state_q == ST_WAIT) || (state_q == ST_CAPTURE)) && bus.gs_out_valid;
    assign m_fire   = (state_q == ST_DRAIN) && m_valid_q && bus.m_ready;

    // NOTE: the data buffers are plain storage with no reset; every word is written before it is read.
    always_ff @(posedge clk) begin
        if (s_accept) bbuf[wcnt_q] <= bus.s_data;
        if (x_store)  xbuf[rcnt_q] <= bus.gs_x;
    end

    // NOTE: every output is a flop updated here with <=, so outputs change only on the clock edge (or reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            dcnt_q     <= '0;
            timer_q    <= '0;
            s_ready_q  <= 1'b0;
            gs_in_en_q <= 1'b0;
            gs_b_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    s_ready_q <= 1'b1;
                    if (s_accept) begin
                        if (wcnt_q == '0) err_q <= 1'b0;
                        if (wcnt_q == LAST) begin
                            wcnt_q     <= '0;
                            state_q    <= ST_SEND;
                            s_ready_q  <= 1'b0;
                            busy_q     <= 1'b1;
                            gs_in_en_q <= 1'b1;
                            gs_b_q     <= (wcnt_q == '0) ? bus.s_data : bbuf[0];
                        end else begin
                            wcnt_q <= wcnt_d;
                        end
                    end
                end

                // wcnt_q tracks which b-word is currently on gs_b
                ST_SEND: begin
                    if (wcnt_q == LAST) begin
                        wcnt_q     <= '0;
                        gs_in_en_q <= 1'b0;
                        gs_b_q     <= '0;
                        timer_q    <= '0;
                        state_q    <= ST_WAIT;
                    end else begin
                        wcnt_q <= wcnt_d;
                        gs_b_q <= bbuf[wcnt_d];
                    end
                end

                ST_WAIT: begin
                    if (bus.gs_out_valid) begin
                        timer_q <= '0;
                        if (N == 1) begin
                            state_q   <= ST_DRAIN;
                            m_valid_q <= 1'b1;
                            m_data_q  <= bus.gs_x;
                        end else begin
                            rcnt_q  <= CW'(1);
                            state_q <= ST_CAPTURE;
                        end
                    end else if (timer_q == TLAST) begin
                        timer_q   <= '0;
                        err_q     <= 1'b1;
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                // GSIM emits its result as one unbroken burst; any gap aborts the solve
                ST_CAPTURE: begin
                    if (bus.gs_out_valid) begin
                        if (rcnt_q == LAST) begin
                            rcnt_q    <= '0;
                            dcnt_q    <= '0;
                            state_q   <= ST_DRAIN;
                            m_valid_q <= 1'b1;
                            m_data_q  <= xbuf[0];
                        end else begin
                            rcnt_q <= rcnt_d;
                        end
                    end else begin
                        rcnt_q    <= '0;
                        err_q     <= 1'b1;
                        state_q   <= ST_LOAD;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    if (m_fire) begin
                        if (dcnt_q == LAST) begin
                            dcnt_q    <= '0;
                            m_valid_q <= 1'b0;
                            m_data_q  <= '0;
                            state_q   <= ST_LOAD;
                            s_ready_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            dcnt_q   <= dcnt_d;
                            m_data_q <= xbuf[dcnt_d];
                        end
                    end
                end

                default: begin
                    state_q <= ST_LOAD;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready  = s_ready_q;
    assign bus.gs_in_en = gs_in_en_q;
    assign bus.gs_b     = gs_b_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gsim_host.sv
// Directed bench for gsim_host: full solves with free-running and stalling drain, WAIT timeout,
// capture gap and reset in the middle of a SEND burst.
module tb_gsim_host;

    localparam int N  = 16;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic busy, err;

    gsim_host_if bus ();

    gsim_host #(.N(N), .TIMEOUT_CYC(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] b_exp [N];
    logic [31:0] x_exp [N];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"},  32'(bus.s_ready),  32'd0);
        check({tag, "_gs_in_en"}, 32'(bus.gs_in_en), 32'd0);
        check({tag, "_gs_b"},     32'(bus.gs_b),     32'd0);
        check({tag, "_m_valid"},  32'(bus.m_valid),  32'd0);
        check({tag, "_m_data"},   bus.m_data,        32'd0);
        check({tag, "_busy"},     32'(busy),         32'd0);
        check({tag, "_err"},      32'(err),          32'd0);
    endtask

    // Streams b_exp with s_valid held high; the last word is accepted on the edge after return.
    task automatic load_words();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("load_s_ready", 32'(bus.s_ready), 32'd1);
            if (i == 1) check("load_err_clear", 32'(err), 32'd0);
            bus.s_valid = 1'b1;
            bus.s_data  = b_exp[i];
        end
    endtask

    // Ends at the negedge of the first WAIT cycle.
    task automatic send_check();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.s_valid = 1'b0;
                check("send_s_ready", 32'(bus.s_ready), 32'd0);
                check("send_busy",    32'(busy),        32'd1);
            end
            check("send_en", 32'(bus.gs_in_en), 32'd1);
            check("send_b",  32'(bus.gs_b),     32'(b_exp[i]));
        end
        @(negedge clk);
        check("send_en_off", 32'(bus.gs_in_en), 32'd0);
        check("send_b_off",  32'(bus.gs_b),     32'd0);
    endtask

    // Drives n contiguous GSIM words starting at the current negedge; ends one negedge after the last.
    task automatic gsim_burst(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            check("capture_m_valid", 32'(bus.m_valid), 32'd0);
            bus.gs_out_valid = 1'b1;
            bus.gs_x         = x_exp[i];
        end
        @(negedge clk);
        bus.gs_out_valid = 1'b0;
        bus.gs_x         = '0;
    endtask

    task automatic drain(input bit toggle);
        int beat = 0;
        int cyc  = 0;
        while (beat < N && cyc < 100) begin
            check("drain_m_valid", 32'(bus.m_valid), 32'd1);
            check("drain_m_data",  bus.m_data,       x_exp[beat]);
            bus.m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            if (bus.m_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        bus.m_ready = 1'b0;
        check("drain_beats",   32'(beat),          32'(N));
        check("drain_end_vld", 32'(bus.m_valid),   32'd0);
        check("drain_s_ready", 32'(bus.s_ready),   32'd1);
        check("drain_busy",    32'(busy),          32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n            = 1'b0;
        bus.s_valid      = 1'b0;
        bus.s_data       = '0;
        bus.gs_out_valid = 1'b0;
        bus.gs_x         = '0;
        bus.m_ready      = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        check("por_s_ready_pre", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        check("por_s_ready_up", 32'(bus.s_ready), 32'd1);

        // Solve 1: b = 1..16, x = 0x00010000*(i+1), host always ready
        for (int i = 0; i < N; i++) begin
            b_exp[i] = 16'(i + 1);
            x_exp[i] = 32'(i + 1) << 16;
        end
        load_words();
        send_check();
        gsim_burst(N);
        drain(1'b0);

        // Solve 2: signed b patterns, late GSIM start, host stalls every other cycle
        for (int i = 0; i < N; i++) begin
            b_exp[i] = 16'hF000 + 16'(i);
            x_exp[i] = 32'h8000_0000 | (32'(i) * 32'h0101_0101);
        end
        load_words();
        send_check();
        repeat (3) @(negedge clk);
        gsim_burst(N);
        drain(1'b1);

        // Timeout: no GSIM response for 64 WAIT cycles
        load_words();
        send_check();
        repeat (TO - 1) @(negedge clk);
        check("to_err_pre",     32'(err),         32'd0);
        check("to_s_ready_pre", 32'(bus.s_ready), 32'd0);
        check("to_busy_pre",    32'(busy),        32'd1);
        @(negedge clk);
        check("to_err",     32'(err),         32'd1);
        check("to_s_ready", 32'(bus.s_ready), 32'd1);
        check("to_busy",    32'(busy),        32'd0);

        // Capture gap: GSIM stops after 5 words; load_words also sees err cleared
        load_words();
        send_check();
        gsim_burst(5);
        @(negedge clk);
        check("gap_err",     32'(err),         32'd1);
        check("gap_s_ready", 32'(bus.s_ready), 32'd1);
        check("gap_m_valid", 32'(bus.m_valid), 32'd0);
        check("gap_busy",    32'(busy),        32'd0);
        @(negedge clk);
        check("gap_m_valid_late", 32'(bus.m_valid), 32'd0);

        // Reset asserted while the 8th b-word is on gs_b
        for (int i = 0; i < N; i++) b_exp[i] = 16'h1234 ^ 16'(i << 8);
        load_words();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) bus.s_valid = 1'b0;
            check("rs_send_b", 32'(bus.gs_b), 32'(b_exp[i]));
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rs_async");
        @(negedge clk);
        check_reset_outputs("rs_held");
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_s_ready_up", 32'(bus.s_ready),  32'd1);
        check("rs_en_idle",    32'(bus.gs_in_en), 32'd0);

        for (int i = 0; i < N; i++) begin
            b_exp[i] = 16'h7FFF - 16'(i);
            x_exp[i] = 32'hFFFF_0000 + 32'(i);
        end
        load_words();
        send_check();
        gsim_burst(N);
        drain(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gsim_host.md
GSIM_HOST -- requirements
Module: gsim_host

Interface
REQ-001 Parameter N, default 16: number of b words sent and x words collected per solve.
REQ-002 Parameter TIMEOUT_CYC, default 4096: maximum cycles from end of SEND to first gs_out_valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  host b-word valid.
REQ-006 s_ready  output  1  block accepts b-word.
REQ-007 s_data  input  16  host b-word, signed Q-format as used by GSIM b_in.
REQ-008 gs_in_en  output  1  drives GSIM in_en.
REQ-009 gs_b  output  16  drives GSIM b_in.
REQ-010 gs_out_valid  input  1  from GSIM out_valid.
REQ-011 gs_x  input  32  from GSIM x_out.
REQ-012 m_valid  output  1  result word valid to host.
REQ-013 m_ready  input  1  host accepts result word.
REQ-014 m_data  output  32  result word x[i].
REQ-015 busy  output  1  high in every state except LOAD.
REQ-016 err  output  1  sticky error flag (timeout or capture gap).

Function
REQ-017 States: LOAD, SEND, WAIT, CAPTURE, DRAIN; all outputs registered.
REQ-018 LOAD: s_ready=1; each cycle with s_valid&&s_ready writes s_data to bbuf[wcnt], wcnt+1; wcnt wraps to 0 on the N-th accept and state -> SEND.
REQ-019 First accept in LOAD clears err.
REQ-020 SEND: s_ready=0; gs_in_en=1 for exactly N consecutive cycles, starting the cycle after the N-th accept; gs_b=bbuf[0..N-1] in order; then gs_in_en=0, gs_b=0, state -> WAIT.
REQ-021 gs_in_en and gs_b are 0 in every state except SEND.
REQ-022 WAIT: timer counts up from 0 each cycle; gs_out_valid=1 stores gs_x to xbuf[0], rcnt=1, state -> CAPTURE.
REQ-023 WAIT: timer reaching TIMEOUT_CYC-1 with gs_out_valid=0 sets err=1, state -> LOAD, result discarded.
REQ-024 CAPTURE: each cycle with gs_out_valid=1 stores gs_x to xbuf[rcnt], rcnt+1; N-th stored word -> DRAIN next cycle.
REQ-025 CAPTURE: any cycle with gs_out_valid=0 before N words sets err=1, state -> LOAD (GSIM output burst is contiguous).
REQ-026 gs_out_valid is ignored in LOAD, SEND and DRAIN.
REQ-027 DRAIN: m_valid=1, m_data=xbuf[dcnt], dcnt from 0; advance on m_valid&&m_ready; m_data held stable while m_valid&&!m_ready.
REQ-028 DRAIN: handshake on dcnt=N-1 deasserts m_valid next cycle, state -> LOAD.
REQ-029 s_valid during SEND/WAIT/CAPTURE/DRAIN is not accepted (s_ready=0); no data lost at host side.
REQ-030 No arithmetic on data: x words passed bit-exact 32 b, b words bit-exact 16 b.

Reset
REQ-031 rst_n low at any time: state=LOAD, wcnt/rcnt/dcnt/timer=0, s_ready=0, gs_in_en=0, gs_b=0, m_valid=0, m_data=0, busy=0, err=0; buffer contents unspecified.
REQ-032 s_ready=1 from the first rising edge after rst_n deassertion.
REQ-033 Reset during SEND drops gs_in_en within the reset assertion (asynchronous), no partial burst resumed.

Verification
REQ-034 Load b=1..16 with s_valid constant -> gs_in_en high 16 cycles, gs_b=1..16, first in cycle after 16th accept.
REQ-035 GSIM model returns x=0x00010000*(i+1) contiguous, m_ready=1 -> m_data 0x00010000..0x00100000, 16 beats, then s_ready=1.
REQ-036 m_ready toggled 1/0 each cycle in DRAIN -> m_data stable during stalls, exactly 16 beats, order preserved.
REQ-037 No gs_out_valid after SEND, TIMEOUT_CYC=64 -> err=1 after 64 WAIT cycles, s_ready=1 next; next accept clears err.
REQ-038 gs_out_valid dropped after 5 words -> err=1, return to LOAD, m_valid never asserted.
REQ-039 rst_n pulsed low mid-SEND (8th word) -> gs_in_en=0 immediately, all outputs at reset values, new 16-word load completes normally.
